// File: rtl/led_pkg.sv
// Shared types and constants for the LED pulse stretcher.
// The optional PWM dimming feature in the top module is enabled by defining LED_PWM_EN.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } led_state_e;

  // Board defaults at 100 MHz: 10 ms on, 5 ms minimum dark gap.
  localparam int ON_CYCLES_DEF  = 1000000;
  localparam int GAP_CYCLES_DEF = 500000;

  localparam int PWM_W = 8;

endpackage

// File: rtl/stretch_timer.sv
// Phase timer for the LED stretcher: up-counter with synchronous clear and a
// terminal-count compare against a caller-supplied limit.
module stretch_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Phase cycle counter; restarts from zero whenever the FSM changes phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == tc_val);

endmodule

// File: rtl/led_pulse_stretch.sv
// Stretches 1-cycle event pulses into visible LED flashes with a minimum on time
// and dark gap, queueing overlapping events. Define LED_PWM_EN to add duty dimming.
module led_pulse_stretch
  import led_pkg::*;
#(
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = 20,
  parameter int PEND_MAX   = 3,
  parameter int PEND_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig,
  input  logic              clr_ovf,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [CNT_W-1:0]  ON_TC    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_TC   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

  led_state_e        state_r;
  led_state_e        state_s;
  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_s;
  logic              ovf_r;
  logic              ovf_s;
  logic              ovf_set_s;
  logic              led_r;
  logic              led_s;
  logic              busy_r;
  logic              pend_nz_s;
  logic              tc_s;
  logic              consume_s;
  logic              tmr_clr_s;
  logic [CNT_W-1:0]  tc_val_s;

  assign tc_val_s  = (state_r == ST_GAP) ? GAP_TC : ON_TC;
  assign tmr_clr_s = (state_r == ST_IDLE) | tc_s;
  assign pend_nz_s = (pend_r != {PEND_W{1'b0}});
  // A gap end with work waiting starts the next flash immediately.
  assign consume_s = (state_r == ST_GAP) & tc_s & (pend_nz_s | trig);

  stretch_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr_s),
    .inc    (~tmr_clr_s),
    .tc_val (tc_val_s),
    .tc     (tc_s)
  );

  // Next-state decode for the IDLE/ON/GAP sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trig) state_s = ST_ON;
        else      state_s = ST_IDLE;
      end
      ST_ON: begin
        if (tc_s) state_s = ST_GAP;
        else      state_s = ST_ON;
      end
      ST_GAP: begin
        if (consume_s)  state_s = ST_ON;
        else if (tc_s)  state_s = ST_IDLE;
        else            state_s = ST_GAP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Pending queue and sticky overflow; a consumed trig never overflows.
  always_comb begin
    pend_s    = pend_r;
    ovf_set_s = 1'b0;
    if (consume_s) begin
      if (pend_nz_s && !trig) pend_s = pend_r - PEND_W'(1'b1);
      else                    pend_s = pend_r;
    end else if (trig && (state_r != ST_IDLE)) begin
      if (pend_r == PEND_TOP) ovf_set_s = 1'b1;
      else                    pend_s    = pend_r + PEND_W'(1'b1);
    end else begin
      pend_s = pend_r;
    end

    if (ovf_set_s)    ovf_s = 1'b1;
    else if (clr_ovf) ovf_s = 1'b0;
    else              ovf_s = ovf_r;
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_r;
  logic [PWM_W-1:0] pwm_nx_s;

  assign pwm_nx_s = pwm_cnt_r + PWM_W'(1'b1);
  // Compare against the value pwm_cnt will hold while led_r is visible.
  assign led_s    = (state_s == ST_ON) & (pwm_nx_s < duty);

  // Free-running dimming counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt_r <= {PWM_W{1'b0}};
    else       pwm_cnt_r <= pwm_nx_s;
  end
`else
  assign led_s = (state_s == ST_ON);
`endif

  // State, queue and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pend_r  <= {PEND_W{1'b0}};
      ovf_r   <= 1'b0;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      led_r   <= led_s;
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign led      = led_r;
  assign busy     = busy_r;
  assign pend_cnt = pend_r;
  assign ovf      = ovf_r;

endmodule
